// File: rtl/fetch_sequencer.sv
// PC / IR sequencer for the nic8 datapath: alternates FETCH and EXEC phases,
// latches opcodes into the IR and steers the PC from the decoder's feedback.
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  bus,
    input  logic        immediate,
    input  logic        doJump,
    input  logic [7:0]  index_addr,
    input  logic        hold,
    input  logic        step,
    output logic [7:0]  ir,
    output logic [7:0]  pc,
    output logic [7:0]  mem_addr,
    output logic        phase,
    output logic        ir_valid,
    output logic        retire,
    output logic [15:0] instr_count
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [7:0]  r_ir;
    logic        r_ir_valid;
    logic [15:0] r_instr_count;

    logic        w_advance;
    logic        w_in_exec;

    // Reset dominates, so a reset cycle never counts as an advance or a retire.
    assign w_advance = !reset && (!hold || step);
    assign w_in_exec = (r_state == ST_EXEC);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_ir          <= 8'h00;
            r_ir_valid    <= 1'b0;
            r_instr_count <= 16'h0000;
        end else if (w_advance) begin
            case (r_state)
                ST_FETCH: begin
                    r_ir       <= bus;
                    r_pc       <= r_pc + 8'd1;
                    r_ir_valid <= 1'b1;
                    r_state    <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (doJump)
                        r_pc <= bus;
                    else if (immediate)
                        r_pc <= r_pc + 8'd1;
                    r_instr_count <= r_instr_count + 16'd1;
                    r_state       <= ST_FETCH;
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Operand address follows the decoder's immediate flag only during EXEC.
    assign mem_addr    = (w_in_exec && !immediate) ? index_addr : r_pc;
    assign retire      = w_in_exec && w_advance;
    assign ir          = r_ir;
    assign pc          = r_pc;
    assign phase       = w_in_exec;
    assign ir_valid    = r_ir_valid;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bus;
    logic        immediate;
    logic        doJump;
    logic [7:0]  index_addr;
    logic        hold;
    logic        step;
    logic [7:0]  ir;
    logic [7:0]  pc;
    logic [7:0]  mem_addr;
    logic        phase;
    logic        ir_valid;
    logic        retire;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state: what the sequencer must hold after each edge.
    logic [7:0]  m_pc;
    logic [7:0]  m_ir;
    bit          m_exec;
    bit          m_valid;
    logic [15:0] m_count;
    bit          m_known = 1'b0;

    fetch_sequencer #(.RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .bus(bus), .immediate(immediate),
        .doJump(doJump), .index_addr(index_addr), .hold(hold), .step(step),
        .ir(ir), .pc(pc), .mem_addr(mem_addr), .phase(phase),
        .ir_valid(ir_valid), .retire(retire), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] actual,
                         input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit advancing();
        return !reset && (!hold || step);
    endfunction

    task automatic compare_model();
        logic [7:0] exp_addr;
        if (!m_known) return;
        exp_addr = (m_exec && !immediate) ? index_addr : m_pc;
        check("pc", {8'h00, pc}, {8'h00, m_pc});
        check("ir", {8'h00, ir}, {8'h00, m_ir});
        check("phase", {15'h0, phase}, {15'h0, m_exec});
        check("ir_valid", {15'h0, ir_valid}, {15'h0, m_valid});
        check("instr_count", instr_count, m_count);
        check("mem_addr", {8'h00, mem_addr}, {8'h00, exp_addr});
        check("retire", {15'h0, retire}, {15'h0, m_exec && advancing()});
    endtask

    // One clock: inputs are already set; compare, then advance the model with the edge.
    task automatic tick();
        #1;
        compare_model();
        @(posedge clk);
        if (reset) begin
            m_pc = 8'h00; m_ir = 8'h00; m_exec = 1'b0; m_valid = 1'b0;
            m_count = 16'h0; m_known = 1'b1;
        end else if (advancing()) begin
            if (!m_exec) begin
                m_ir = bus; m_pc = m_pc + 8'd1; m_valid = 1'b1;
            end else begin
                m_pc = doJump ? bus : (immediate ? m_pc + 8'd1 : m_pc);
                m_count = m_count + 16'd1;
            end
            m_exec = !m_exec;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; bus = 8'h00; immediate = 1'b0; doJump = 1'b0;
        index_addr = 8'h00; hold = 1'b0; step = 1'b0;
        @(negedge clk);
        tick(); tick();
        #1;
        check("reset_pc", {8'h00, pc}, 16'h0000);
        check("reset_mem_addr", {8'h00, mem_addr}, 16'h0000);
        check("reset_ir_valid", {15'h0, ir_valid}, 16'h0);

        // Free-running: constant opcode 0x24 with immediate operands.
        reset = 1'b0; bus = 8'h24; immediate = 1'b1; doJump = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("run_retire", {15'h0, retire}, (k % 2 == 0) ? 16'h1 : 16'h0);
            tick();
        end
        check("run_pc", {8'h00, pc}, 16'h0004);
        check("run_ir", {8'h00, ir}, 16'h0024);
        check("run_count", instr_count, 16'h0002);

        // Jump with immediate set: jump wins.
        tick();
        doJump = 1'b1; bus = 8'h80;
        tick();
        check("jump_pc", {8'h00, pc}, 16'h0080);
        check("jump_fetch_addr", {8'h00, mem_addr}, 16'h0080);

        // Indexed operand with pc = 0x11.
        doJump = 1'b0; bus = 8'h01; tick();
        doJump = 1'b1; bus = 8'h10; tick();
        doJump = 1'b0; bus = 8'h07; tick();
        immediate = 1'b0; index_addr = 8'h3C;
        #1;
        check("index_addr_out", {8'h00, mem_addr}, 16'h003C);
        tick();
        check("index_pc_kept", {8'h00, pc}, 16'h0011);

        // PC wrap from 0xFF across FETCH and an immediate EXEC.
        tick();
        doJump = 1'b1; immediate = 1'b1; bus = 8'hFF; tick();
        doJump = 1'b0; check("wrap_start", {8'h00, pc}, 16'h00FF);
        tick();
        check("wrap_fetch", {8'h00, pc}, 16'h0000);
        tick();
        check("wrap_exec", {8'h00, pc}, 16'h0001);

        // Hold / single-step.
        hold = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("hold_pc", {8'h00, pc}, 16'h0001);
        check("hold_phase", {15'h0, phase}, 16'h0);
        step = 1'b1; tick(); step = 1'b0; tick();
        check("step_one_phase", {15'h0, phase}, 16'h1);
        check("step_one_pc", {8'h00, pc}, 16'h0002);
        step = 1'b1; tick(); tick(); tick(); step = 1'b0;
        check("step_three_phase", {15'h0, phase}, 16'h0);
        hold = 1'b0;

        // Reset in EXEC with a pending jump.
        tick();
        reset = 1'b1; doJump = 1'b1; bus = 8'h55;
        #1;
        check("reset_no_retire", {15'h0, retire}, 16'h0);
        tick();
        check("rst_exec_pc", {8'h00, pc}, 16'h0000);
        check("rst_exec_phase", {15'h0, phase}, 16'h0);
        check("rst_exec_valid", {15'h0, ir_valid}, 16'h0);
        check("rst_exec_count", instr_count, 16'h0000);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            reset      = ($urandom_range(99) == 0);
            bus        = 8'($urandom);
            immediate  = 1'($urandom);
            doJump     = ($urandom_range(3) == 0);
            index_addr = 8'($urandom);
            hold       = ($urandom_range(3) == 0);
            step       = 1'($urandom);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter / instruction-register sequencer for the nic8 datapath: it holds the PC, fetches each opcode byte from memory into the IR, and drives the 8-bit `ir` consumed by the combinational control decoder. It alternates fetch and execute phases. In the execute phase it takes the decoder's `immediate` and `doJump` outputs back in to decide where the PC goes next. Single-step hold logic for the bench/front panel lives here too.

## Interface
- `RESET_PC`, 8'h00, PC value loaded by reset
- `clk` input 1: sole clock; all state updates on rising edge
- `reset` input 1: synchronous, active-high; wins over every other input
- `bus` input 8: data bus value; opcode in FETCH, operand/jump target in EXEC
- `immediate` input 1: from decoder; operand is at PC (1) or at `index_addr` (0)
- `doJump` input 1: from decoder; load PC from `bus` at end of EXEC
- `index_addr` input 8: X-register address used for non-immediate operands
- `hold` input 1: freeze sequencer when high
- `step` input 1: one-cycle pulse; advances exactly one phase while `hold`=1
- `ir` output 8: instruction register, to decoder
- `pc` output 8: program counter
- `mem_addr` output 8: memory address for current phase
- `phase` output 1: 0=FETCH, 1=EXEC
- `ir_valid` output 1: low until first opcode fetched after reset
- `retire` output 1: high for the EXEC cycle that completes an instruction
- `instr_count` output 16: retired-instruction counter

## Operation
- State machine has two states: FETCH (phase=0) and EXEC (phase=1).
- The sequencer *advances* in a cycle when `hold`=0, or when `hold`=1 and `step`=1.
- FETCH:
  - `mem_addr`=`pc`.
  - On advance: `ir`<=`bus`, `pc`<=`pc`+1, `ir_valid`<=1, go to EXEC.
- EXEC:
  - `mem_addr` = `immediate` ? `pc` : `index_addr`.
  - On advance, the PC update has this priority:
    - `doJump`=1: `pc`<=`bus`.
    - else `immediate`=1: `pc`<=`pc`+1.
    - else `pc` is unchanged.
  - Also on advance: `instr_count`<=`instr_count`+1, go to FETCH.
- `retire` = phase==EXEC && advance (combinational).
- `immediate` and `doJump` are sampled only in EXEC. They are ignored in FETCH, because `ir` is not yet stable for the new instruction.
- When not advancing, `pc`, `ir`, phase, `ir_valid` and `instr_count` all hold their values. `mem_addr` still tracks the current-phase rule.
- `step` while `hold`=0 has no additional effect; the sequencer advances once per cycle, never twice.

## Timing
- Reset values: `pc`=`RESET_PC`, `ir`=8'h00, phase=FETCH, `ir_valid`=0, `instr_count`=0, `retire`=0, `mem_addr`=`RESET_PC`.
- Free-running throughput: one instruction per 2 cycles.
- Latency:
  - `ir` updates on the edge ending FETCH.
  - The decoder sees the new opcode during the following EXEC cycle.
  - A jump target appears on `pc` on the edge ending EXEC, and is fetched in the next cycle.
- Arithmetic wrap-around:
  - PC is 8 bits and wraps: 8'hFF+1 = 8'h00, both after FETCH and after an immediate EXEC.
  - `instr_count` wraps from 16'hFFFF to 0.
- Jump with `immediate`=1: the jump wins; `pc`=`bus`, with no increment.
- Reset asserted mid-EXEC: next state is FETCH at `RESET_PC`; no retire is counted.
- `reset` and `step` together: reset wins.
- `hold` rising in the middle of a program: the freeze takes effect in the same cycle; the current phase repeats until `step` or `hold`=0.

## Test plan
- Reset with `RESET_PC`=8'h00, `hold`=0, `bus`=8'h24 constant, `immediate`=1, `doJump`=0 -> after 4 cycles: `pc`=8'h04, `ir`=8'h24, `instr_count`=2, `retire` pulses on cycles 2 and 4.
- Jump: in EXEC drive `doJump`=1, `immediate`=1, `bus`=8'h80 -> `pc`=8'h80 after the edge; the next FETCH has `mem_addr`=8'h80.
- Indexed: in EXEC drive `immediate`=0, `index_addr`=8'h3C, `pc`=8'h11 -> `mem_addr`=8'h3C, and `pc` stays 8'h11 after the edge.
- Wrap: start from `pc`=8'hFF in FETCH, immediate operand -> `pc`=8'h00, then 8'h01.
- Hold/step: `hold`=1 for 10 cycles -> no state change. One `step` pulse -> exactly one phase advance. `step` held 3 cycles -> three advances.
- Reset asserted in EXEC with `doJump`=1, `bus`=8'h55 -> `pc`=`RESET_PC`, phase=FETCH, `ir_valid`=0, `instr_count` unchanged by that cycle and reset to 0.
